universal_shift_reg: RTL and testbench
======================================

Name: universal_shift_reg

Overview:
- Parametrised successor to the team's single-bit master-slave D flip-flop.
- A WIDTH-bit edge-triggered register with eight per-cycle operations: hold, load, logical shifts, rotates, arithmetic shift, clear.
- Adds a burst engine that repeats one latched operation N times under a Start/Busy/Done handshake.
- Sits behind switch/LED glue in lab top levels, and serves as the shift/hold datapath for later serial and arithmetic labs.

Parameters:
- WIDTH, 8, register width in bits (legal range 2 to 32).
- CNT_W, 4, width of the burst count input; maximum burst is 2**CNT_W-1 operations.
- RESET_VAL, 0, value loaded into Q on reset (WIDTH bits).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- En  input  1  single-step enable; in IDLE, applies Mode once at this edge.
- Mode  input  3  operation select (encoding in Behaviour).
- D  input  WIDTH  parallel load data.
- Sin_L  input  1  serial bit entering at the MSB on logical shift right.
- Sin_R  input  1  serial bit entering at the LSB on shift left.
- Start  input  1  begin a burst of Count operations of the current Mode.
- Count  input  CNT_W  number of operations in the burst.
- Q  output  WIDTH  register contents.
- Sout_L  output  1  equals Q[WIDTH-1] (combinational).
- Sout_R  output  1  equals Q[0] (combinational).
- Busy  output  1  high while a burst is executing.
- Done  output  1  one-cycle pulse at burst completion.
- Par  output  1  parity of Q (see Optional Feature).

Behaviour:
- Clocking and reset: one clock domain, Clk. Resetn is asynchronous and active-low.
- Reset values while Resetn=0: Q=RESET_VAL, Busy=0, Done=0, state=IDLE, remaining count=0, latched mode=000.
- Mode encoding (op applied at one edge):
  - 000 hold.
  - 001 load: Q<=D.
  - 010 shift left: Q<={Q[W-2:0],Sin_R}.
  - 011 logical shift right: Q<={Sin_L,Q[W-1:1]}.
  - 100 rotate left: Q<={Q[W-2:0],Q[W-1]}.
  - 101 rotate right: Q<={Q[0],Q[W-1:1]}.
  - 110 arithmetic shift right: Q<={Q[W-1],Q[W-1:1]}.
  - 111 clear: Q<=0.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - Start=1 and Count>=1: latch Mode, remaining<=Count, go to BUSY, Busy<=1. Q is unchanged at this edge.
  - Start=1 and Count=0: stay in IDLE, Q unchanged, Done<=1 for one cycle.
  - Start=0 and En=1: apply Mode once at this edge.
  - Start and En both high: Start wins; En is ignored.
  - Otherwise: hold.
- BUSY:
  - Each edge applies the latched mode and decrements remaining.
  - The edge that applies the final op (remaining==1) returns to IDLE, clears Busy and sets Done for exactly one cycle.
  - A burst of N therefore updates Q at edges 1..N after the Start edge. Busy is high for N cycles; Done is high in the cycle after the Nth update.
  - Start, En, Mode and Count are ignored while BUSY.
  - D, Sin_L and Sin_R are sampled live on every burst edge, not latched.
- Done is registered and is otherwise 0. A new Start may be accepted in the same cycle that Done is high.
- Reset asserted mid-burst: immediate abort to reset values. No Done pulse.
- Sout_L, Sout_R and Par are combinational from Q and add no latency.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined: Par = XOR-reduction of Q, combinational, valid in the same cycle as Q.
- Undefined: Par tied to 0 and no parity logic is synthesised. The port list is identical in both builds.

Test Plan:
- Reset: Resetn=0 mid-cycle with Q=8'hA5 -> Q=8'h00, Busy=0 and Done=0 immediately, with no clock edge needed.
- Single-step sequence:
  - En=1, Mode=001, D=8'h96 -> Q=8'h96.
  - Mode=100 -> 8'h2D.
  - Mode=110 -> 8'h16.
  - Mode=011 with Sin_L=1 -> 8'h8B.
  - Sout_R=1.
- Burst:
  - Setup: Q=8'h81, Start=1, Mode=101, Count=3.
  - Busy is high for exactly 3 cycles.
  - Q steps through 8'hC0, 8'h60, 8'h30.
  - Done is high in the single following cycle.
  - Start, En and Mode changes during Busy have no effect.
- Count=0 Start -> Q unchanged, Busy stays 0, one-cycle Done pulse. Start+En together in IDLE -> only the burst starts.
- Abort: Resetn pulsed low at the 2nd cycle of a Count=5 shift-left burst -> Q=RESET_VAL, Busy=0, no Done.
- Parity (USR_PARITY_EN defined):
  - Load 8'h07 -> Par=1.
  - Load 8'h03 -> Par=0.
  - With the macro undefined -> Par=0 always.

Source files
------------

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - WIDTH-bit universal shift register with burst engine; optional parity via USR_PARITY_EN
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             Sin_L,
  input  logic             Sin_R,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  output logic [WIDTH-1:0] Q,
  output logic             Sout_L,
  output logic             Sout_R,
  output logic             Busy,
  output logic             Done,
  output logic             Par
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [2:0]       mode_lat, mode_lat_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;

  // One edge worth of the selected operation; D and serial inputs are taken live.
  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] din,
                                                input logic sl,
                                                input logic sr);
    logic [WIDTH-1:0] res;
    case (op)
      3'b001:  res = din;
      3'b010:  res = {cur[WIDTH-2:0], sr};
      3'b011:  res = {sl, cur[WIDTH-1:1]};
      3'b100:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  res = {cur[0], cur[WIDTH-1:1]};
      3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      3'b111:  res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  // State, register contents, burst bookkeeping and the Done pulse.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      remaining <= '0;
      mode_lat  <= 3'b000;
      Q         <= RESET_VAL;
      Done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      mode_lat  <= mode_lat_nxt;
      Q         <= q_nxt;
      Done      <= done_nxt;
    end
  end

  // Next-state: Start beats En in IDLE; BUSY runs the latched op until remaining hits 1.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    mode_lat_nxt  = mode_lat;
    q_nxt         = Q;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (Count != '0) begin
            state_nxt     = BUSY;
            remaining_nxt = Count;
            mode_lat_nxt  = Mode;
          end else begin
            done_nxt = 1'b1;
          end
        end else if (En) begin
          q_nxt = apply_op(Mode, Q, D, Sin_L, Sin_R);
        end
      end
      BUSY: begin
        q_nxt         = apply_op(mode_lat, Q, D, Sin_L, Sin_R);
        remaining_nxt = remaining - 1'b1;
        if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy   = (state == BUSY);
  assign Sout_L = Q[WIDTH-1];
  assign Sout_R = Q[0];

`ifdef USR_PARITY_EN
  assign Par = ^Q;
`else
  assign Par = 1'b0;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - table-driven bench for universal_shift_reg
module tb_universal_shift_reg;

  logic       Clk = 1'b0;
  logic       Resetn;
  logic       En;
  logic [2:0] Mode;
  logic [7:0] D;
  logic       Sin_L;
  logic       Sin_R;
  logic       Start;
  logic [3:0] Count;
  logic [7:0] Q;
  logic       Sout_L;
  logic       Sout_R;
  logic       Busy;
  logic       Done;
  logic       Par;

  universal_shift_reg #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
    .Clk(Clk), .Resetn(Resetn), .En(En), .Mode(Mode), .D(D),
    .Sin_L(Sin_L), .Sin_R(Sin_R), .Start(Start), .Count(Count),
    .Q(Q), .Sout_L(Sout_L), .Sout_R(Sout_R), .Busy(Busy), .Done(Done), .Par(Par)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       en;
    logic       start;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [3:0] cnt;
    logic [7:0] eq;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_par(input logic [7:0] v);
`ifdef USR_PARITY_EN
    return ^v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_in(input vec_t v);
    En = v.en; Start = v.start; Mode = v.mode; D = v.d;
    Sin_L = v.sl; Sin_R = v.sr; Count = v.cnt;
  endtask

  task automatic idle_in();
    En = 1'b0; Start = 1'b0; Mode = 3'b000; D = 8'h00;
    Sin_L = 1'b0; Sin_R = 1'b0; Count = 4'd0;
  endtask

  initial begin
    //              en    st    mode    d      sl    sr    cnt    q      busy  done
    tbl[0]  = '{1'b1, 1'b0, 3'b001, 8'h96, 1'b0, 1'b0, 4'd0, 8'h96, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 4'd0, 8'h2D, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3'b110, 8'h00, 1'b0, 1'b0, 4'd0, 8'h16, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 3'b011, 8'h00, 1'b1, 1'b0, 4'd0, 8'h8B, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 3'b001, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h8B, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 3'b010, 8'h00, 1'b1, 1'b0, 4'd0, 8'h16, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 3'b101, 8'h00, 1'b0, 1'b0, 4'd0, 8'h0B, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 3'b111, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 3'b001, 8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 4'd3, 8'h81, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0, 4'd7, 8'hC0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 3'b111, 8'h00, 1'b0, 1'b0, 4'd0, 8'h60, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0, 8'h30, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0, 8'h30, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 3'b001, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h30, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0, 8'h30, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 4'd1, 8'h30, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0, 8'h60, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 4'd2, 8'h60, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 4'd0, 8'hC1, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0, 8'h82, 1'b0, 1'b1};
    tbl[21] = '{1'b1, 1'b0, 3'b110, 8'h00, 1'b0, 1'b0, 4'd0, 8'hC1, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 3'b001, 8'h07, 1'b0, 1'b0, 4'd0, 8'h07, 1'b0, 1'b0};
    tbl[23] = '{1'b1, 1'b0, 3'b001, 8'h03, 1'b0, 1'b0, 4'd0, 8'h03, 1'b0, 1'b0};

    Resetn = 1'b0;
    idle_in();
    #12;
    chk("reset_q", 32'(Q), 32'h00);
    chk("reset_busy", 32'(Busy), 32'(1'b0));
    chk("reset_done", 32'(Done), 32'(1'b0));
    @(negedge Clk);
    Resetn = 1'b1;

    for (int i = 0; i < 24; i++) begin
      set_in(tbl[i]);
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d_q", i), 32'(Q), 32'(tbl[i].eq));
      chk($sformatf("vec%0d_busy", i), 32'(Busy), 32'(tbl[i].eb));
      chk($sformatf("vec%0d_done", i), 32'(Done), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_sout_l", i), 32'(Sout_L), 32'(tbl[i].eq[7]));
      chk($sformatf("vec%0d_sout_r", i), 32'(Sout_R), 32'(tbl[i].eq[0]));
      chk($sformatf("vec%0d_par", i), 32'(Par), 32'(exp_par(tbl[i].eq)));
    end

    // Asynchronous reset mid-cycle with Q=A5, checked before the next edge.
    idle_in();
    En = 1'b1; Mode = 3'b001; D = 8'hA5;
    @(posedge Clk);
    #1;
    chk("load_a5", 32'(Q), 32'hA5);
    idle_in();
    #2;
    Resetn = 1'b0;
    #1;
    chk("async_rst_q", 32'(Q), 32'h00);
    chk("async_rst_busy", 32'(Busy), 32'(1'b0));
    chk("async_rst_done", 32'(Done), 32'(1'b0));
    @(negedge Clk);
    Resetn = 1'b1;

    // Abort a Count=5 shift-left burst in its second cycle.
    En = 1'b1; Mode = 3'b001; D = 8'h01;
    @(posedge Clk);
    #1;
    chk("abort_load", 32'(Q), 32'h01);
    idle_in();
    Start = 1'b1; Mode = 3'b010; Count = 4'd5;
    @(posedge Clk);
    #1;
    chk("abort_start_busy", 32'(Busy), 32'(1'b1));
    chk("abort_start_q", 32'(Q), 32'h01);
    idle_in();
    @(posedge Clk);
    #1;
    chk("abort_step1_q", 32'(Q), 32'h02);
    chk("abort_step1_busy", 32'(Busy), 32'(1'b1));
    #2;
    Resetn = 1'b0;
    #1;
    chk("abort_q", 32'(Q), 32'h00);
    chk("abort_busy", 32'(Busy), 32'(1'b0));
    chk("abort_done", 32'(Done), 32'(1'b0));
    @(negedge Clk);
    Resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk);
      #1;
      chk($sformatf("post_abort%0d_done", k), 32'(Done), 32'(1'b0));
      chk($sformatf("post_abort%0d_busy", k), 32'(Busy), 32'(1'b0));
      chk($sformatf("post_abort%0d_q", k), 32'(Q), 32'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
